// File: rtl/axi4_line_refill.sv
// Read-only AXI4 master: one cache-miss request becomes one burst read of a whole line.
// Optional build macro REFILL_CRITICAL_WORD_FIRST_EN: missed word first via WRAP burst.
module axi4_line_refill #(
  parameter int         BEATS  = 4,
  parameter logic [3:0] AXI_ID = 4'd0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           req_addr,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [64*BEATS-1:0]   resp_line,
  output logic                  resp_err,
  output logic                  arvalid,
  input  logic                  arready,
  output logic [3:0]            arid,
  output logic [31:0]           araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic                  rready,
  input  logic                  rvalid,
  input  logic [3:0]            rid,
  input  logic [63:0]           rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast
);

  localparam int          IDX_W     = $clog2(BEATS);
  localparam logic [31:0] LINE_MASK = 32'(BEATS*8-1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_AR   = 2'd1;
  localparam logic [1:0] ST_R    = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [31:0]         addr_q, addr_d;
  logic [IDX_W-1:0]    cnt_q, cnt_d;
  logic [64*BEATS-1:0] line_q, line_d;
  logic                err_q, err_d;

  logic [IDX_W-1:0]    slot_idx;
  logic                last_cnt;
  logic                beat_err;

`ifdef REFILL_CRITICAL_WORD_FIRST_EN
  // Beats arrive starting at the missed word, so rotate the slot by its line offset.
  assign slot_idx = addr_q[3 +: IDX_W] + cnt_q;
  assign araddr   = {addr_q[31:3], 3'b000};
  assign arburst  = 2'b10;
`else
  assign slot_idx = cnt_q;
  assign araddr   = addr_q & ~LINE_MASK;
  assign arburst  = 2'b01;
`endif

  assign last_cnt = (cnt_q == IDX_W'(BEATS-1));
  assign beat_err = (rresp == 2'b10) || (rresp == 2'b11) || (rid != AXI_ID);

  assign req_ready  = (state_q == ST_IDLE);
  assign arvalid    = (state_q == ST_AR);
  assign rready     = (state_q == ST_R);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_line  = line_q;
  assign resp_err   = err_q;
  assign arid       = AXI_ID;
  assign arlen      = 8'(BEATS-1);
  assign arsize     = 3'd3;

  always_comb begin
    // NOTE: every next-state value gets its hold default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          state_d = ST_AR;
        end
      end
      ST_AR: begin
        if (arready) state_d = ST_R;
      end
      ST_R: begin
        if (rvalid) begin
          for (int i = 0; i < BEATS; i++) begin
            if (slot_idx == IDX_W'(i)) line_d[i*64 +: 64] = rdata;
          end
          cnt_d = cnt_q + 1'b1;
          // Early or missing rlast is a protocol error but still terminates the burst.
          err_d = err_q | beat_err | (rlast != last_cnt);
          if (rlast || last_cnt) state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
          err_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      // NOTE: the line storage is reset too, because resp_line must read zero out of reset.
      line_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      err_q   <= err_d;
    end
  end

endmodule
